// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and defaults for the 3-master round-robin arbiter
package bus_arb_pkg;

  localparam int NUM_MASTERS = 3;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int BE_W        = 4;

  localparam logic [31:0] SLAVE_START_DEF     = 32'h0;
  localparam logic [31:0] SLAVE_SIZE_DEF      = 32'h8000;
  localparam int          MAX_OUTSTANDING_DEF = 4;

  typedef logic [1:0] master_id_t;

  // Round-robin successor over the three masters.
  function automatic master_id_t rr_next(input master_id_t id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

endpackage

// File: rtl/bus_if.sv
// rtl/bus_if.sv - simple req/gnt bus with in-order read response
interface bus_if;
  import bus_arb_pkg::*;

  logic              req;
  logic              gnt;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/bus_resp_id_fifo.sv
// rtl/bus_resp_id_fifo.sv - in-order queue of granted master ids awaiting a response
module bus_resp_id_fifo
  import bus_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push,
  input  logic       pop,
  input  master_id_t id_in,
  output master_id_t id_out,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  master_id_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign id_out  = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= id_in;
  end

endmodule

// File: rtl/bus_arbiter_rr3m1s.sv
// rtl/bus_arbiter_rr3m1s.sv - round-robin arbiter, three masters onto one windowed slave
module bus_arbiter_rr3m1s
  import bus_arb_pkg::*;
#(
  parameter logic [31:0] SLAVE_START     = SLAVE_START_DEF,
  parameter logic [31:0] SLAVE_SIZE      = SLAVE_SIZE_DEF,
  parameter int          MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  bus_if.slave  master0,
  bus_if.slave  master1,
  bus_if.slave  master2,
  bus_if.master slave,
  output logic  spurious_o
);

  localparam logic [ADDR_W-1:0] MASK = ~(SLAVE_SIZE - 32'd1);

  logic [NUM_MASTERS-1:0] m_req;
  logic [ADDR_W-1:0]      m_addr  [NUM_MASTERS];
  logic                   m_we    [NUM_MASTERS];
  logic [BE_W-1:0]        m_be    [NUM_MASTERS];
  logic [DATA_W-1:0]      m_wdata [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] qual;

  master_id_t             last_grant;
  master_id_t             sel_id;
  master_id_t             cand;
  logic                   sel_valid;
  logic                   handshake;
  logic [NUM_MASTERS-1:0] gnt_vec;
  logic [NUM_MASTERS-1:0] rv_vec;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  master_id_t             head_id;

  logic [ADDR_W-1:0]      s_addr;
  logic                   s_we;
  logic [BE_W-1:0]        s_be;
  logic [DATA_W-1:0]      s_wdata;

  assign m_req      = {master2.req, master1.req, master0.req};
  assign m_addr[0]  = master0.addr;
  assign m_addr[1]  = master1.addr;
  assign m_addr[2]  = master2.addr;
  assign m_we[0]    = master0.we;
  assign m_we[1]    = master1.we;
  assign m_we[2]    = master2.we;
  assign m_be[0]    = master0.be;
  assign m_be[1]    = master1.be;
  assign m_be[2]    = master2.be;
  assign m_wdata[0] = master0.wdata;
  assign m_wdata[1] = master1.wdata;
  assign m_wdata[2] = master2.wdata;

  always_comb begin
    for (int k = 0; k < NUM_MASTERS; k++) begin
      qual[k] = m_req[k] & ((m_addr[k] & MASK) == SLAVE_START);
    end
  end

  // Search starts just after the last granted master; a full queue or reset blocks everything.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = 2'd0;
    cand      = rr_next(last_grant);
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!sel_valid && qual[cand]) begin
        sel_valid = 1'b1;
        sel_id    = cand;
      end
      cand = rr_next(cand);
    end
    if (fifo_full || !rst_ni) sel_valid = 1'b0;
  end

  always_comb begin
    s_addr  = '0;
    s_we    = 1'b0;
    s_be    = '0;
    s_wdata = '0;
    if (sel_valid) begin
      s_addr  = m_addr[sel_id];
      s_we    = m_we[sel_id];
      s_be    = m_be[sel_id];
      s_wdata = m_wdata[sel_id];
    end
  end

  assign slave.req   = sel_valid;
  assign slave.addr  = s_addr;
  assign slave.we    = s_we;
  assign slave.be    = s_be;
  assign slave.wdata = s_wdata;

  assign handshake = sel_valid & slave.gnt;

  always_comb begin
    gnt_vec = '0;
    if (handshake) gnt_vec[sel_id] = 1'b1;
  end

  assign master0.gnt = gnt_vec[0];
  assign master1.gnt = gnt_vec[1];
  assign master2.gnt = gnt_vec[2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant <= 2'd2;
    end else if (handshake) begin
      last_grant <= sel_id;
    end
  end

  bus_resp_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (handshake),
    .pop    (fifo_pop),
    .id_in  (sel_id),
    .id_out (head_id),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Responses are routed to the queue head; a response with nothing queued is flagged, not routed.
  assign fifo_pop   = slave.rvalid & ~fifo_empty & rst_ni;
  assign spurious_o = slave.rvalid & fifo_empty & rst_ni;

  always_comb begin
    rv_vec = '0;
    if (fifo_pop) rv_vec[head_id] = 1'b1;
  end

  assign master0.rvalid = rv_vec[0];
  assign master1.rvalid = rv_vec[1];
  assign master2.rvalid = rv_vec[2];
  assign master0.rdata  = rv_vec[0] ? slave.rdata : '0;
  assign master1.rdata  = rv_vec[1] ? slave.rdata : '0;
  assign master2.rdata  = rv_vec[2] ? slave.rdata : '0;
  assign master0.err    = rv_vec[0] & slave.err;
  assign master1.err    = rv_vec[1] & slave.err;
  assign master2.err    = rv_vec[2] & slave.err;

endmodule

// File: doc/bus_arbiter_rr3m1s.md
BUS_ARBITER_RR3M1S -- requirements
Module: bus_arbiter_rr3m1s

Interface
REQ-001 SHALL have parameter SLAVE_START, default 32'h0, base address of the shared slave window.
REQ-002 SHALL have parameter SLAVE_SIZE, default 32'h8000, window size; power of two; mask = ~(SLAVE_SIZE-1).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, depth of the response-routing queue; power of two, 2..16.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports master0, master1, master2  bus_if.slave  bus_if (req, gnt, addr, we, be, wdata, rvalid, rdata, err)  requesting masters.
REQ-007 SHALL have port slave  bus_if.master  bus_if  shared slave.
REQ-008 SHALL have port spurious_o  output  1  one-cycle pulse when slave.rvalid arrives with no outstanding transfer.

Function
REQ-009 SHALL qualify master k request as mk.req & ((mk.addr & mask) == SLAVE_START); unqualified requests never receive gnt.
REQ-010 SHALL select exactly one qualified master per cycle, round-robin: search starts at master (last_grant+1) mod 3.
REQ-011 SHALL forward the selected master's req, addr, we, be, wdata to slave combinationally, and drive selected mk.gnt = slave.gnt; all other gnt = 0.
REQ-012 SHALL drive slave.req/addr/we/be/wdata = 0 when no master is selected.
REQ-013 SHALL update last_grant to the selected index only on handshake (slave.req & slave.gnt); no handshake leaves last_grant unchanged.
REQ-014 SHALL push the selected master id into the response queue on every handshake; grant-to-queue latency 0 (visible next cycle).
REQ-015 SHALL pop the queue on every slave.rvalid, routing slave.rdata/rvalid/err to the master at queue head in that same cycle; other masters see rdata=0, rvalid=0, err=0.
REQ-016 SHALL support one push and one pop in the same cycle, leaving occupancy unchanged.
REQ-017 SHALL, when the queue holds MAX_OUTSTANDING entries, force slave.req = 0 and all gnt = 0 in that cycle, even if slave.rvalid pops in the same cycle (full blocks unconditionally).
REQ-018 SHALL, on slave.rvalid with empty queue, not pop, drive no master rvalid, and pulse spurious_o for that cycle.
REQ-019 SHALL wrap queue read/write pointers modulo MAX_OUTSTANDING; occupancy counter width clog2(MAX_OUTSTANDING)+1.
REQ-020 SHALL be purely combinational from master request inputs to slave request outputs (no added request latency).

Reset
REQ-021 SHALL on rst_ni low set last_grant = 2 (master0 has first priority), queue empty, pointers 0, spurious_o = 0.
REQ-022 SHALL, on reset asserted mid-transfer, discard all outstanding queue entries; responses arriving after reset release are treated per REQ-018.
REQ-023 SHALL drive all gnt, rvalid, err = 0 while rst_ni is low.

Structure
REQ-024 SHALL place master-id typedef (2-bit), NUM_MASTERS = 3 constant, and default window constants in shared package bus_arb_pkg.
REQ-025 SHALL implement the response queue as sub-module bus_resp_id_fifo (push, pop, id in/out, full, empty).
REQ-026 SHALL contain no latches; every combinational output has a default assignment.

Verification
REQ-027 SHALL test: m0, m1, m2 all request 32'h100 continuously, slave.gnt = 1 -> gnt order m0, m1, m2, m0, ...
REQ-028 SHALL test: m1 requests 32'h9000 (outside window), m2 requests 32'h10 -> only m2 granted; m1.gnt stays 0.
REQ-029 SHALL test: 4 handshakes (m0, m1, m0, m2) with rvalid withheld -> 5th request not granted; rvalid x4 with rdata 0xA0..0xA3 -> routed to m0, m1, m0, m2 in order.
REQ-030 SHALL test: queue holds 2, handshake and rvalid in same cycle -> occupancy remains 2, head routed correctly.
REQ-031 SHALL test: slave.rvalid with empty queue -> spurious_o = 1 for one cycle, no master rvalid.
REQ-032 SHALL test: rst_ni pulsed low with 3 outstanding -> queue empty, next grant goes to m0.
